uart_rx_data_sampler: RTL

- Front-end stage of the UART receiver, directly upstream of the parity checker.
- Counts oversampling edges and bit positions, and majority-votes RX_IN around each bit centre.
- Shifts data bits LSB-first into P_DATA.
- The RX FSM drives cnt_en and deser_en; sampled_bit and P_DATA feed the parity, start and stop checkers.

---
 rtl/uart_rx_data_sampler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_rx_data_sampler.sv
// UART RX front end: oversample counters, bit-centre voting, LSB-first deserialiser.
// `define RX_MAJORITY_VOTE_EN for a 3-sample vote; default uses the centre sample only.
module uart_rx_data_sampler #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk_RX,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  cnt_en,
  input  logic                  deser_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic [DATA_WIDTH-1:0] P_DATA
);

  logic                  cnt_en_q;
  logic                  en_rise;
  logic [PRESCALE_W-1:0] p_q;
  logic [PRESCALE_W-1:0] p_new;
  logic [PRESCALE_W-1:0] p_eff;
  logic [PRESCALE_W-1:0] half;
  logic                  edge_last;
  logic                  at_s1;
  logic                  at_s2;
  logic                  vote;

  always_comb begin
    p_new = PRESCALE_W'(8);
    unique case (1'b1)
      (Prescale == PRESCALE_W'(16)): p_new = Prescale;
      (Prescale == PRESCALE_W'(32)): p_new = Prescale;
      default:                       p_new = PRESCALE_W'(8);
    endcase
  end

  // the first enabled cycle already uses the freshly latched ratio
  assign en_rise   = cnt_en & ~cnt_en_q;
  assign p_eff     = en_rise ? p_new : p_q;
  assign half      = p_eff >> 1;
  assign edge_last = (edge_cnt == p_eff - PRESCALE_W'(1));
  assign at_s1     = (edge_cnt == half);
  assign at_s2     = (edge_cnt == half + PRESCALE_W'(1));

`ifdef RX_MAJORITY_VOTE_EN
  logic s0;
  logic s1;
  logic at_s0;

  assign at_s0 = (edge_cnt == half - PRESCALE_W'(1));

  always_ff @(posedge clk_RX) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else if (cnt_en) begin
      if (at_s0) s0 <= RX_IN;
      if (at_s1) s1 <= RX_IN;
    end
  end

  // third sample is taken straight off the line on the voting edge
  assign vote = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
`else
  logic s1;

  always_ff @(posedge clk_RX) begin
    if (rst) begin
      s1 <= 1'b0;
    end else if (cnt_en && at_s1) begin
      s1 <= RX_IN;
    end
  end

  assign vote = s1;
`endif

  always_ff @(posedge clk_RX) begin
    if (rst) begin
      cnt_en_q     <= 1'b0;
      p_q          <= '0;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      bit_done     <= 1'b0;
      sampled_bit  <= 1'b0;
      sample_valid <= 1'b0;
      P_DATA       <= '0;
    end else begin
      cnt_en_q     <= cnt_en;
      bit_done     <= 1'b0;
      sample_valid <= 1'b0;
      if (!cnt_en) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (en_rise) p_q <= p_new;
        if (edge_last) begin
          edge_cnt <= '0;
          bit_done <= 1'b1;
          if (bit_cnt != '1)
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end else begin
          edge_cnt <= edge_cnt + PRESCALE_W'(1);
        end
        if (at_s2) begin
          sampled_bit  <= vote;
          sample_valid <= 1'b1;
          if (deser_en)
            P_DATA <= {vote, P_DATA[DATA_WIDTH-1:1]};
        end
      end
    end
  end

endmodule
